// File: rtl/nla_pkg.sv
// nla_pkg: shared types and constants for the NLA Horner scheduler.
//   func_e     : activation select (SELU exp-series / TanH odd series)
//   state_e    : scheduler FSM states
//   mac_req_t  : one (a, b, c) issue to the MAC, result = a*b + c
//   FP_*       : FP32 constants used for special-case results
//   *_COEF     : coefficient tables, index 0 = highest order term
//   is_nan()   : FP32 quiet/signalling NaN detect
package nla_pkg;

  localparam int NLA_TERMS = 10;

  typedef enum logic [0:0] {FUNC_SELU = 1'b0, FUNC_TANH = 1'b1} func_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } mac_req_t;

  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP_ONE     = 32'h3F800000;
  localparam logic [31:0] TANH_CLAMP = 32'h40900000;

  // sum x^j/(j+1)!, j = 9..0 -> (e^x - 1)/x
  localparam logic [0:NLA_TERMS-1][31:0] SELU_COEF = {
    32'h3493F27D, 32'h3638EF1D, 32'h37D00D01, 32'h39500D01, 32'h3AB60B61,
    32'h3C088889, 32'h3D2AAAAB, 32'h3E2AAAAB, 32'h3F000000, 32'h3F800000
  };

  // Taylor series of tanh: 62/2835 x^9 - 17/315 x^7 + 2/15 x^5 - 1/3 x^3 + x
  localparam logic [0:NLA_TERMS-1][31:0] TANH_COEF = {
    32'h3CB327A4, 32'h00000000, 32'hBD5D0DD1, 32'h00000000, 32'h3E088889,
    32'h00000000, 32'hBEAAAAAB, 32'h00000000, 32'h3F800000, 32'h00000000
  };

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/nla_coeff_rom.sv
// nla_coeff_rom: combinational coefficient lookup.
//   func : function select
//   k    : term index, 0 = highest order; out-of-range reads return 0
//   coef : FP32 coefficient
module nla_coeff_rom
  import nla_pkg::*;
#(
  parameter int K_W = 4
) (
  input  func_e          func,
  input  logic [K_W-1:0] k,
  output logic [31:0]    coef
);

  always_comb begin
    coef = 32'd0;
    if (int'(k) < NLA_TERMS)
      coef = (func == FUNC_TANH) ? TANH_COEF[k] : SELU_COEF[k];
  end

endmodule

// File: rtl/nla_horner_sched.sv
// nla_horner_sched: drives an external FP32 MAC through a Horner evaluation
// acc = acc*x + c[k] of the selected activation polynomial.
//   in_*        : operand x + function select, valid/ready (ready only in IDLE)
//   mac_*_o     : one-cycle issue strobe with a=acc, b=x, c=c[k]
//   mac_result* : MAC result strobe, only consumed while waiting on an issue
//   out_*       : polynomial value, valid held until out_ready_i
//   err_o       : one-cycle pulse on NaN operand or MAC timeout
// Optional feature macro NLA_TANH_CLAMP_EN: TanH operands with |x| >= 4.5
// bypass the MAC and return sign(x)*1.0 directly.
module nla_horner_sched
  import nla_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_TERMS   = 10,
  parameter int FUNC_W      = 1,
  parameter int MAC_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [FUNC_W-1:0]     in_func_i,
  output logic                  mac_valid_o,
  output logic [DATA_WIDTH-1:0] mac_a_o,
  output logic [DATA_WIDTH-1:0] mac_b_o,
  output logic [DATA_WIDTH-1:0] mac_c_o,
  input  logic                  mac_result_valid_i,
  input  logic [DATA_WIDTH-1:0] mac_result_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  err_o
);

  localparam int K_W = $clog2(NUM_TERMS);
  localparam int T_W = $clog2(MAC_TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, x_q;
  func_e                 func_q;
  logic [K_W-1:0]        k_q;
  logic [T_W-1:0]        tmo_q;
  logic                  err_q;

  func_e                 in_func, rom_func;
  logic [K_W-1:0]        rom_k;
  logic [31:0]           coef;
  logic                  clamp, last_term, tmo_hit;
  mac_req_t              mac_req;

  assign in_func   = func_e'(in_func_i[0]);
  assign last_term = (k_q == K_W'(NUM_TERMS - 1));
  assign tmo_hit   = (tmo_q == T_W'(MAC_TIMEOUT - 1));

`ifdef NLA_TANH_CLAMP_EN
  // Magnitude compare on the raw bits is valid for any non-NaN FP32 value.
  assign clamp = (in_func == FUNC_TANH) && (in_data_i[30:0] >= TANH_CLAMP[30:0]);
`else
  assign clamp = 1'b0;
`endif

  // Single ROM shared between the accept-time c[0] fetch and issue-time c[k].
  assign rom_func = (state_q == ST_IDLE) ? in_func : func_q;
  assign rom_k    = (state_q == ST_IDLE) ? '0 : k_q;

  nla_coeff_rom #(.K_W(K_W)) u_rom (
    .func (rom_func),
    .k    (rom_k),
    .coef (coef)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    mac_valid_o = 1'b0;
    out_valid_o = 1'b0;
    mac_req     = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i)
          state_d = (is_nan(in_data_i) || clamp) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        mac_valid_o = 1'b1;
        mac_req.a   = acc_q;
        mac_req.b   = x_q;
        mac_req.c   = coef;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (mac_result_valid_i) state_d = last_term ? ST_DONE : ST_ISSUE;
        else if (tmo_hit)       state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // acc doubles as the result register: special cases overwrite it on the
  // way into DONE so out_data_o needs no extra mux.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      x_q    <= '0;
      func_q <= FUNC_SELU;
      k_q    <= '0;
      tmo_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (in_valid_i) begin
          x_q    <= in_data_i;
          func_q <= in_func;
          k_q    <= K_W'(1);
          if (is_nan(in_data_i)) begin
            acc_q <= FP_QNAN;
            err_q <= 1'b1;
          end else if (clamp) begin
            acc_q <= {in_data_i[DATA_WIDTH-1], FP_ONE[30:0]};
          end else begin
            acc_q <= coef;
          end
        end
        ST_ISSUE: tmo_q <= '0;
        ST_WAIT: begin
          if (mac_result_valid_i) begin
            acc_q <= mac_result_i;
            if (!last_term) k_q <= k_q + 1'b1;
          end else if (tmo_hit) begin
            acc_q <= FP_QNAN;
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mac_a_o    = mac_req.a;
  assign mac_b_o    = mac_req.b;
  assign mac_c_o    = mac_req.c;
  assign out_data_o = acc_q;
  assign err_o      = err_q;

endmodule
